// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, baud divisor and counter width helpers.
// ST_PARITY exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } uart_state_e;

   function automatic int uart_div(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   // Bits needed to hold DIV-1 (DIV is at least 2, so this is never 0)
   function automatic int uart_cnt_w(input int div);
      return $clog2(div);
   endfunction

   localparam int UART_DEF_DIV   = uart_div(27000000, 115200);
   localparam int UART_DEF_CNT_W = uart_cnt_w(UART_DEF_DIV);

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the host controller and the UART transmitter, plus the TX pin.
interface uart_tx_if;
   logic [7:0] dataIn;
   logic       byteReady;
   logic       byteSending;
   logic       txDone;
   logic       uartTx;

   modport master (output dataIn, byteReady, input byteSending, txDone, uartTx);
   modport slave  (input dataIn, byteReady, output byteSending, txDone, uartTx);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1, tick marks the last cycle of a bit period.
// clr holds the count at 0; the count also wraps to 0 after each tick.
module uart_baud_gen import uart_pkg::*; #(
   parameter int DIV   = 2,
   parameter int CNT_W = uart_cnt_w(DIV)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clr || tick) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1/8N2, LSB first, idle-high; all outputs registered.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1/8E2).
module uart_tx import uart_pkg::*; #(
   parameter int CLK_FREQ  = 27000000,
   parameter int BAUD_RATE = 115200,
   parameter int STOP_BITS = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   uart_tx_if.slave tx_if
);
   localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE);
   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   if (DIV < 2) begin : g_bad_div
      $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

   uart_state_e state_d, state_q;
   logic [7:0]  shift_d, shift_q;
   logic [2:0]  idx_d, idx_q;
   logic        tx_d, tx_q;
   logic        busy_d, busy_q;
   logic        done_d, done_q;
`ifdef UART_TX_PARITY_EN
   logic        par_d, par_q;
`endif
   logic        tick;

   // Counter is held clear in IDLE; every other transition happens on a tick, which wraps it
   uart_baud_gen #(.DIV(DIV)) u_baud (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (state_q == ST_IDLE),
      .tick (tick)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (tx_if.byteReady) begin
               state_d = ST_START;
               shift_d = tx_if.dataIn;
               idx_d   = '0;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
               par_d   = ^tx_if.dataIn;
`endif
            end
         end
         ST_START: if (tick) begin
            state_d = ST_DATA;
            idx_d   = '0;
            tx_d    = shift_q[0];
         end
         ST_DATA: if (tick) begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[1];
            if (idx_q == 3'd7) begin
               idx_d   = '0;
`ifdef UART_TX_PARITY_EN
               state_d = ST_PARITY;
               tx_d    = par_q;
`else
               state_d = ST_STOP;
               tx_d    = 1'b1;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: if (tick) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
         end
`endif
         ST_STOP: if (tick) begin
            // idx counts completed stop bits
            if (idx_q == STOP_LAST) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign tx_if.uartTx      = tx_q;
   assign tx_if.byteSending = busy_q;
   assign tx_if.txDone      = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV=8: one DUT with one stop bit, one with two.
// Line activity is captured every falling edge and compared slot by slot afterwards.
module tb_uart_tx;
   localparam int DIV  = 8;
   localparam int NCAP = 2048;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int F1 = (10 + PAR) * DIV;
   localparam int F2 = (11 + PAR) * DIV;

   logic       clk;
   logic       rst_n;
   logic       req;
   logic [7:0] din;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [NCAP-1:0] tx_a, busy_a, done_a, tx_b, busy_b, done_b;

   uart_tx_if if_a ();
   uart_tx_if if_b ();
   assign if_a.dataIn    = din;
   assign if_a.byteReady = req;
   assign if_b.dataIn    = din;
   assign if_b.byteReady = req;

   uart_tx #(.CLK_FREQ(8), .BAUD_RATE(1), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .tx_if(if_a));
   uart_tx #(.CLK_FREQ(8), .BAUD_RATE(1), .STOP_BITS(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .tx_if(if_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (cyc < NCAP) begin
         tx_a[cyc]   <= if_a.uartTx;
         busy_a[cyc] <= if_a.byteSending;
         done_a[cyc] <= if_a.txDone;
         tx_b[cyc]   <= if_b.uartTx;
         busy_b[cyc] <= if_b.byteSending;
         done_b[cyc] <= if_b.txDone;
      end
      cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic s_tx(input int d, input int i);
      if (i < 0 || i >= NCAP) return 1'bx;
      return (d != 0) ? tx_b[i] : tx_a[i];
   endfunction
   function automatic logic s_busy(input int d, input int i);
      if (i < 0 || i >= NCAP) return 1'bx;
      return (d != 0) ? busy_b[i] : busy_a[i];
   endfunction
   function automatic logic s_done(input int d, input int i);
      if (i < 0 || i >= NCAP) return 1'bx;
      return (d != 0) ? done_b[i] : done_a[i];
   endfunction

   // Check one captured frame whose first START sample is at index st
   task automatic check_frame(input string tag, input int d, input int st,
                              input logic [7:0] b, input int nstop);
      int nslot;
      int flen;
      int nb;
      logic [7:0] got;
      logic exp_bit;
      nslot = 9 + PAR + nstop;
      flen  = nslot * DIV;
      for (int j = 0; j < nslot; j++) begin
         if (j == 0)                   exp_bit = 1'b0;
         else if (j <= 8)              exp_bit = b[j-1];
         else if (PAR == 1 && j == 9)  exp_bit = ^b;
         else                          exp_bit = 1'b1;
         for (int k = 0; k < DIV; k++) got[k] = s_tx(d, st + j*DIV + k);
         check($sformatf("%s slot%0d", tag, j), 32'(got), 32'({8{exp_bit}}));
      end
      nb = 0;
      for (int i = st; i < st + flen; i++) nb += int'(s_busy(d, i));
      check($sformatf("%s busy_len", tag), 32'(nb), 32'(flen));
      check($sformatf("%s busy_pre", tag), 32'(s_busy(d, st - 1)), 32'(0));
      check($sformatf("%s busy_post", tag), 32'(s_busy(d, st + flen)), 32'(0));
      check($sformatf("%s done_pulse", tag),
            32'({s_done(d, st + flen - 1), s_done(d, st + flen), s_done(d, st + flen + 1)}),
            32'(3'b010));
      check($sformatf("%s idle_line", tag), 32'(s_tx(d, st + flen)), 32'(1));
   endtask

   // Raise the request for one edge; st is the index of the first START sample
   task automatic send(input logic [7:0] b, output int st);
      din = b;
      req = 1'b1;
      st  = cyc + 1;
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_a"}, 32'({if_a.uartTx, if_a.byteSending, if_a.txDone}), 32'(3'b100));
      check({tag, "_b"}, 32'({if_b.uartTx, if_b.byteSending, if_b.txDone}), 32'(3'b100));
   endtask

   initial begin
      int st;
      rst_n = 1'b0;
      req   = 1'b0;
      din   = 8'h00;
      idle_cycles(3);
      check_idle("reset");
      rst_n = 1'b1;
      idle_cycles(2);

      // Basic frame, 0x50
      send(8'h50, st);
      idle_cycles(F2 + 6);
      check_frame("basic_a", 0, st, 8'h50, 1);
      check_frame("basic_b", 1, st, 8'h50, 2);

      // Held request: dut_a sends two frames with one idle cycle between them
      din = 8'h58;
      req = 1'b1;
      st  = cyc + 1;
      idle_cycles(F1 + 4);
      req = 1'b0;
      idle_cycles(F2 + 10);
      check_frame("held1_a", 0, st, 8'h58, 1);
      check_frame("held2_a", 0, st + F1 + 1, 8'h58, 1);
      check_frame("held_b", 1, st, 8'h58, 2);

      // dataIn changes during DATA must not leak into the frame
      send(8'h50, st);
      idle_cycles(20);
      din = 8'hFF;
      idle_cycles(F2 + 4);
      din = 8'h00;
      check_frame("chg_a", 0, st, 8'h50, 1);
      check_frame("chg_b", 1, st, 8'h50, 2);

      // Reset during bit 3, with the request held high throughout
      send(8'h50, st);
      idle_cycles(35);
      check("pre_rst_bit3", 32'(if_a.uartTx), 32'(0));
      rst_n = 1'b0;
      req   = 1'b1;
      din   = 8'hA5;
      idle_cycles(1);
      check_idle("rst_mid");
      idle_cycles(4);
      check_idle("rst_hold");
      req   = 1'b0;
      rst_n = 1'b1;
      idle_cycles(3);
      check_idle("rst_after");

      send(8'h58, st);
      idle_cycles(F2 + 6);
      check_frame("recov_a", 0, st, 8'h58, 1);
      check_frame("recov_b", 1, st, 8'h58, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
